// File: rtl/threshold_monitor.sv
// Debounced threshold-crossing detector: hysteresis FSM over Comparator gt/lt flags,
// with rise/fall events and their sample-index stamps queued in a small valid/ready FIFO.
module threshold_monitor #(
    parameter  int DEBOUNCE  = 3,
    parameter  int CNT_W     = 4,
    parameter  int STAMP_W   = 8,
    parameter  int EVT_DEPTH = 4,
    localparam int PTR_W     = $clog2(EVT_DEPTH),
    localparam int OCC_W     = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               gt,
    input  logic               lt,
    input  logic               flag_clr,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic               evt_rise,
    output logic [STAMP_W-1:0] evt_stamp,
    output logic               level,
    output logic [OCC_W-1:0]   evt_count,
    output logic               overflow,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_RISING  = 2'd1,
        ST_HIGH    = 2'd2,
        ST_FALLING = 2'd3
    } state_t;

    localparam logic [CNT_W:0]     DEB_V     = (CNT_W+1)'(DEBOUNCE);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [STAMP_W-1:0] STAMP_ONE = STAMP_W'(1);
    localparam logic [OCC_W-1:0]   DEPTH_V   = OCC_W'(EVT_DEPTH);
    localparam logic [OCC_W-1:0]   OCC_ONE   = OCC_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic               DEB_ONE   = (DEBOUNCE == 1);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [STAMP_W-1:0]   stamp_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [OCC_W-1:0]     count_q;
    logic                 overflow_q;
    logic                 err_q;
    logic [STAMP_W:0]     mem_q [EVT_DEPTH];

    logic                 s_above;
    logic                 s_below;
    logic                 s_illegal;
    logic [CNT_W:0]       cnt_inc;
    logic                 done_rise;
    logic                 done_fall;
    logic                 push_req;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [STAMP_W:0]     head;

    // Sample classification; EQUAL and idle cycles qualify as neither direction.
    assign s_above   = in_valid &  gt & ~lt;
    assign s_below   = in_valid &  lt & ~gt;
    assign s_illegal = in_valid &  gt &  lt;

    // One extra bit so the debounce compare never aliases on counter wrap.
    assign cnt_inc   = {1'b0, cnt_q} + {1'b0, CNT_ONE};

    assign done_rise = s_above & (((state_q == ST_LOW) & DEB_ONE) |
                                  ((state_q == ST_RISING) & (cnt_inc == DEB_V)));
    assign done_fall = s_below & (((state_q == ST_HIGH) & DEB_ONE) |
                                  ((state_q == ST_FALLING) & (cnt_inc == DEB_V)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_LOW: begin
                    if (s_above) begin
                        if (DEB_ONE) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_RISING;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                ST_RISING: begin
                    if (done_rise) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                    end else if (s_above) begin
                        cnt_q   <= cnt_inc[CNT_W-1:0];
                    end else if (s_below) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                    end
                end
                ST_HIGH: begin
                    if (s_below) begin
                        if (DEB_ONE) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_FALLING;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                ST_FALLING: begin
                    if (done_fall) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                    end else if (s_below) begin
                        cnt_q   <= cnt_inc[CNT_W-1:0];
                    end else if (s_above) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level = (state_q == ST_HIGH) | (state_q == ST_FALLING);

    // Every valid sample consumes an index, including EQUAL and ILLEGAL ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp_q <= '0;
        end else if (in_valid) begin
            stamp_q <= stamp_q + STAMP_ONE;
        end
    end

    assign push_req = done_rise | done_fall;
    assign full     = (count_q == DEPTH_V);
    assign evt_valid = (count_q != '0);
    assign pop      = evt_valid & evt_ready;
    // A pop frees the slot this same edge, so a full FIFO still accepts the push.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {done_rise, stamp_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + OCC_ONE;
                2'b01:   count_q <= count_q - OCC_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is gated so unwritten storage never reaches the outputs.
    assign head      = mem_q[rd_ptr_q];
    assign evt_rise  = evt_valid & head[STAMP_W];
    assign evt_stamp = evt_valid ? head[STAMP_W-1:0] : '0;
    assign evt_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            overflow_q <= drop      | (overflow_q & ~flag_clr);
            err_q      <= s_illegal | (err_q      & ~flag_clr);
        end
    end

    assign overflow = overflow_q;
    assign err      = err_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// Self-checking bench for threshold_monitor: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of debounce, stamps and event FIFO.
module tb_threshold_monitor;

    localparam int DEB   = 3;
    localparam int DEPTH = 4;
    localparam int SMOD  = 256;

    localparam int C_IDLE  = 0;
    localparam int C_ABOVE = 1;
    localparam int C_BELOW = 2;
    localparam int C_EQUAL = 3;
    localparam int C_ILL   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       gt;
    logic       lt;
    logic       flag_clr;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_rise;
    logic [7:0] evt_stamp;
    logic       level;
    logic [2:0] evt_count;
    logic       overflow;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: current level, length of the current run of samples pulling
    // away from it, sample index, sticky flags and the event queue.
    bit m_level;
    int m_run;
    int m_stamp;
    bit m_err;
    bit m_ovf;
    bit q_rise[$];
    int q_stamp[$];

    threshold_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .gt        (gt),
        .lt        (lt),
        .flag_clr  (flag_clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_rise  (evt_rise),
        .evt_stamp (evt_stamp),
        .level     (level),
        .evt_count (evt_count),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_level = 1'b0;
        m_run   = 0;
        m_stamp = 0;
        m_err   = 1'b0;
        m_ovf   = 1'b0;
        q_rise.delete();
        q_stamp.delete();
    endtask

    // Drive one cycle, advance the model with the same inputs, land 1ns after the edge.
    task automatic step(input int cls, input bit rdy, input bit clr);
        bit do_pop;
        bit set_err;
        bit set_ovf;
        bit toward_high;
        bit pulls;
        in_valid  = (cls != C_IDLE);
        gt        = (cls == C_ABOVE) || (cls == C_ILL);
        lt        = (cls == C_BELOW) || (cls == C_ILL);
        evt_ready = rdy;
        flag_clr  = clr;
        do_pop  = rdy && (q_rise.size() > 0);
        set_err = 1'b0;
        set_ovf = 1'b0;
        if (do_pop) begin
            void'(q_rise.pop_front());
            void'(q_stamp.pop_front());
        end
        if (cls != C_IDLE) begin
            if (cls == C_ILL) begin
                set_err = 1'b1;
            end else if (cls != C_EQUAL) begin
                toward_high = (cls == C_ABOVE);
                pulls = (toward_high != m_level);
                if (pulls) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_level = toward_high;
                        m_run   = 0;
                        if (q_rise.size() < DEPTH) begin
                            q_rise.push_back(toward_high);
                            q_stamp.push_back(m_stamp);
                        end else begin
                            set_ovf = 1'b1;
                        end
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_stamp = (m_stamp + 1) % SMOD;
        end
        m_err = set_err || (m_err && !clr);
        m_ovf = set_ovf || (m_ovf && !clr);
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int cls, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(cls, rdy, 1'b0);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        gt        = 1'b0;
        lt        = 1'b0;
        flag_clr  = 1'b0;
        evt_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; gt = 1'b0; lt = 1'b0; flag_clr = 1'b0; evt_ready = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({evt_valid, evt_rise, evt_stamp, level, evt_count, overflow, err} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {evt_valid, evt_rise, evt_stamp, level, evt_count, overflow, err});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_rise_basic();
        apply_reset();
        step_n(C_ABOVE, 2, 1'b1);
        checks++;
        if (level !== 1'b0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_pre level=%b valid=%b exp level=0 valid=0", level, evt_valid);
        end
        step(C_ABOVE, 1'b1, 1'b0);
        checks++;
        if (level !== 1'b1 || evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_stamp !== 8'd2 || evt_count !== 3'd1) begin
            failures++;
            $display("FAIL basic_rise level=%b valid=%b rise=%b stamp=%0d count=%0d exp 1 1 1 2 1",
                     level, evt_valid, evt_rise, evt_stamp, evt_count);
        end
        step(C_IDLE, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0 || level !== 1'b1) begin
            failures++;
            $display("FAIL basic_pop valid=%b count=%0d level=%b exp 0 0 1", evt_valid, evt_count, level);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        step_n(C_ABOVE, 2, 1'b1);
        step(C_BELOW, 1'b1, 1'b0);
        step_n(C_ABOVE, 2, 1'b1);
        checks++;
        if (level !== 1'b0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL bounce_pre level=%b valid=%b exp 0 0", level, evt_valid);
        end
        step(C_ABOVE, 1'b1, 1'b0);
        checks++;
        if (level !== 1'b1 || evt_count !== 3'd1 || evt_rise !== 1'b1 || evt_stamp !== 8'd5) begin
            failures++;
            $display("FAIL bounce_rise level=%b count=%0d rise=%b stamp=%0d exp 1 1 1 5",
                     level, evt_count, evt_rise, evt_stamp);
        end
    endtask

    task automatic test_deadband();
        apply_reset();
        step(C_ABOVE, 1'b1, 1'b0);
        step(C_IDLE,  1'b1, 1'b0);
        step(C_EQUAL, 1'b1, 1'b0);
        step(C_IDLE,  1'b1, 1'b0);
        step(C_ABOVE, 1'b1, 1'b0);
        step(C_IDLE,  1'b1, 1'b0);
        checks++;
        if (level !== 1'b0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL deadband_pre level=%b valid=%b exp 0 0", level, evt_valid);
        end
        step(C_ABOVE, 1'b1, 1'b0);
        checks++;
        if (level !== 1'b1 || evt_valid !== 1'b1 || evt_stamp !== 8'd3) begin
            failures++;
            $display("FAIL deadband_rise level=%b valid=%b stamp=%0d exp 1 1 3", level, evt_valid, evt_stamp);
        end
    endtask

    task automatic test_overflow();
        bit exp_rise[4];
        int exp_stamp[4];
        exp_rise  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_stamp = '{2, 5, 8, 11};
        apply_reset();
        for (int k = 0; k < 5; k++) step_n((k % 2 == 0) ? C_ABOVE : C_BELOW, DEB, 1'b0);
        checks++;
        if (evt_count !== 3'd4 || overflow !== 1'b1 || level !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full count=%0d ovf=%b level=%b exp 4 1 1", evt_count, overflow, level);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_rise !== exp_rise[k] || evt_stamp !== exp_stamp[k][7:0]) begin
                failures++;
                $display("FAIL ovf_drain%0d valid=%b rise=%b stamp=%0d exp 1 %b %0d",
                         k, evt_valid, evt_rise, evt_stamp, exp_rise[k], exp_stamp[k]);
            end
            step(C_IDLE, 1'b1, 1'b0);
        end
        checks++;
        if (evt_count !== 3'd0 || evt_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_empty count=%0d valid=%b ovf=%b exp 0 0 1", evt_count, evt_valid, overflow);
        end
        step(C_IDLE, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 4; k++) step_n((k % 2 == 0) ? C_ABOVE : C_BELOW, DEB, 1'b0);
        step_n(C_ABOVE, DEB - 1, 1'b0);
        step(C_ABOVE, 1'b1, 1'b0);
        checks++;
        if (evt_count !== 3'd4 || overflow !== 1'b0 || evt_rise !== 1'b0 || evt_stamp !== 8'd5) begin
            failures++;
            $display("FAIL b2b_full_pushpop count=%0d ovf=%b rise=%b stamp=%0d exp 4 0 0 5",
                     evt_count, overflow, evt_rise, evt_stamp);
        end
        step_n(C_IDLE, 3, 1'b1);
        checks++;
        if (evt_count !== 3'd1 || evt_rise !== 1'b1 || evt_stamp !== 8'd14) begin
            failures++;
            $display("FAIL b2b_tail count=%0d rise=%b stamp=%0d exp 1 1 14", evt_count, evt_rise, evt_stamp);
        end
        step(C_IDLE, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        apply_reset();
        step(C_ABOVE, 1'b1, 1'b0);
        step(C_ILL,   1'b1, 1'b0);
        checks++;
        if (err !== 1'b1 || level !== 1'b0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL ill_flag err=%b level=%b valid=%b exp 1 0 0", err, level, evt_valid);
        end
        step(C_ABOVE, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL ill_cnt_held valid=%b exp 0", evt_valid);
        end
        step(C_ABOVE, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b1 || evt_stamp !== 8'd3 || level !== 1'b1) begin
            failures++;
            $display("FAIL ill_rise valid=%b stamp=%0d level=%b exp 1 3 1", evt_valid, evt_stamp, level);
        end
        step(C_ILL, 1'b1, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL ill_set_wins err=%b exp 1", err);
        end
        step(C_IDLE, 1'b1, 1'b1);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL ill_clear err=%b exp 0", err);
        end
    endtask

    task automatic test_wrap_reset();
        apply_reset();
        step_n(C_EQUAL, 260, 1'b1);
        step(C_ABOVE, 1'b0, 1'b0);
        step(C_EQUAL, 1'b0, 1'b0);
        step_n(C_ABOVE, 2, 1'b0);
        checks++;
        if (evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_stamp !== 8'd7) begin
            failures++;
            $display("FAIL wrap_stamp valid=%b rise=%b stamp=%0d exp 1 1 7", evt_valid, evt_rise, evt_stamp);
        end
        step(C_BELOW, 1'b0, 1'b0);
        checks++;
        if (level !== 1'b1 || evt_count !== 3'd1) begin
            failures++;
            $display("FAIL wrap_falling level=%b count=%0d exp 1 1", level, evt_count);
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (level !== 1'b0 || evt_valid !== 1'b0 || evt_count !== 3'd0 || overflow !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset level=%b valid=%b count=%0d ovf=%b err=%b exp all 0",
                     level, evt_valid, evt_count, overflow, err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step_n(C_ABOVE, DEB, 1'b1);
        checks++;
        if (evt_valid !== 1'b1 || evt_stamp !== 8'd2) begin
            failures++;
            $display("FAIL reset_stamp valid=%b stamp=%0d exp 1 2", evt_valid, evt_stamp);
        end
        step(C_IDLE, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int trend;
        int r;
        int cls;
        bit rdy;
        bit clr;
        bit exp_valid;
        apply_reset();
        trend = C_ABOVE;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 11) == 0) trend = (trend == C_ABOVE) ? C_BELOW : C_ABOVE;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 3) == 0)  cls = C_IDLE;
            else if (r < 3)                 cls = C_ILL;
            else if (r < 15)                cls = C_EQUAL;
            else if (r < 85)                cls = trend;
            else                            cls = (trend == C_ABOVE) ? C_BELOW : C_ABOVE;
            rdy = ((cyc / 60) % 3 == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 24) == 0);
            step(cls, rdy, clr);
            exp_valid = (q_rise.size() > 0);
            checks++;
            if (level !== m_level || evt_valid !== exp_valid || evt_count !== 3'(q_rise.size())
                || overflow !== m_ovf || err !== m_err) begin
                failures++;
                $display("FAIL rand_state cyc=%0d level=%b valid=%b count=%0d ovf=%b err=%b exp %b %b %0d %b %b",
                         cyc, level, evt_valid, evt_count, overflow, err,
                         m_level, exp_valid, q_rise.size(), m_ovf, m_err);
            end
            if (exp_valid) begin
                checks++;
                if (evt_rise !== q_rise[0] || evt_stamp !== q_stamp[0][7:0]) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d rise=%b stamp=%0d exp %b %0d",
                             cyc, evt_rise, evt_stamp, q_rise[0], q_stamp[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_basic();
        test_bounce();
        test_deadband();
        test_overflow();
        test_back_to_back();
        test_illegal();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
